// File: rtl/mem_access_if.sv
// ----------------------------------------------------------------------------
// mem_access_if
//   Data-memory request/acknowledge bus between the memory-access stage
//   (master) and the data memory (slave).
//   req    master->slave  access request, held until ack or abort
//   we     master->slave  1 = store, 0 = load (valid while req)
//   addr   master->slave  word address, low two bits always zero
//   be     master->slave  byte enables, lane 0 = bits [7:0]
//   wdata  master->slave  store data, byte/half replicated across lanes
//   ack    slave->master  access completes this cycle
//   rdata  slave->master  load word, valid in the ack cycle
// ----------------------------------------------------------------------------
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access.sv
// ----------------------------------------------------------------------------
// mem_access
//   Memory-access pipeline stage sitting directly after EX. Non-memory ops
//   pass their write-back fields through one register stage. Loads/stores run
//   a req/ack handshake on the dmem bus (IDLE -> BUS -> DONE), holding
//   stallreq_o while the access is outstanding; load data is aligned and
//   sign-extended before being registered toward MEM/WB. A bus access that
//   sees no ack for ACK_TIMEOUT cycles is aborted with a bus_err_o pulse.
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   valid_i, aluop_i         live instruction and its operation code
//   mem_addr_i, reg2_i       effective address, store data
//   wd_i, wreg_i, wdata_i    write-back fields for non-load ops
//   pc_i                     instruction pc
//   wd_o, wreg_o, wdata_o    registered write-back fields
//   pc_o                     registered pc
//   stallreq_o               stall request (combinational from state)
//   dmem                     data-memory bus (mem_access_if.master)
//   bus_err_o                one-cycle pulse on timeout / misalignment
// Build option
//   MEM_ALIGN_CHECK_EN       when defined, misaligned LH/SH/LW/SW are not
//                            issued on the bus and raise bus_err_o instead.
// ----------------------------------------------------------------------------
`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef ALU_OP_LB
`define ALU_OP_LB 8'b1110_0000
`define ALU_OP_LH 8'b1110_0001
`define ALU_OP_LW 8'b1110_0011
`define ALU_OP_SB 8'b1110_1000
`define ALU_OP_SH 8'b1110_1001
`define ALU_OP_SW 8'b1110_1011
`define ALU_OP_ORI 8'b0010_0101
`endif
`ifndef InitialPc
`define InitialPc 32'hBFC0_0000
`endif

module mem_access #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [`AluOpBus]  aluop_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [31:0]       pc_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic [31:0]       pc_o,
    output logic              stallreq_o,
    mem_access_if.master      dmem,
    output logic              bus_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    function automatic logic is_mem_op(input logic [`AluOpBus] op);
        case (op)
            `ALU_OP_LB, `ALU_OP_LH, `ALU_OP_LW,
            `ALU_OP_SB, `ALU_OP_SH, `ALU_OP_SW: is_mem_op = 1'b1;
            default:                            is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [`AluOpBus] op);
        case (op)
            `ALU_OP_SB, `ALU_OP_SH, `ALU_OP_SW: is_store = 1'b1;
            default:                            is_store = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [`AluOpBus] op, input logic [1:0] off);
        case (op)
            `ALU_OP_LB, `ALU_OP_SB: byte_en = 4'b0001 << off;
            `ALU_OP_LH, `ALU_OP_SH: byte_en = off[1] ? 4'b1100 : 4'b0011;
            `ALU_OP_LW, `ALU_OP_SW: byte_en = 4'b1111;
            default:                byte_en = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [`AluOpBus] op, input logic [31:0] d);
        case (op)
            `ALU_OP_SB: store_data = {4{d[7:0]}};
            `ALU_OP_SH: store_data = {2{d[15:0]}};
            default:    store_data = d;
        endcase
    endfunction

    function automatic logic [31:0] align_load(input logic [`AluOpBus] op, input logic [1:0] off,
                                               input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            2'd3:    b = d[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (op)
            `ALU_OP_LB: align_load = {{24{b[7]}}, b};
            `ALU_OP_LH: align_load = {{16{h[15]}}, h};
            default:    align_load = d;
        endcase
    endfunction

`ifdef MEM_ALIGN_CHECK_EN
    function automatic logic is_misaligned(input logic [`AluOpBus] op, input logic [1:0] off);
        case (op)
            `ALU_OP_LH, `ALU_OP_SH: is_misaligned = off[0];
            `ALU_OP_LW, `ALU_OP_SW: is_misaligned = (off != 2'b00);
            default:                is_misaligned = 1'b0;
        endcase
    endfunction
`endif

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [4:0]        wd_q, wd_d;
    logic              wreg_q, wreg_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       pc_q, pc_d;
    // Copy of the issued instruction so the ack cycle does not depend on EX holding still.
    logic [`AluOpBus]  op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        hwd_q, hwd_d;
    logic              hwreg_q, hwreg_d;
    logic [31:0]       hpc_q, hpc_d;
    logic              mem_req_s;
    logic              misalign_s;
    logic              stall_s;

    assign mem_req_s = valid_i & is_mem_op(aluop_i);

    // Alignment qualification of the instruction presented in IDLE.
    always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
        misalign_s = is_misaligned(aluop_i, mem_addr_i[1:0]);
`else
        misalign_s = 1'b0;
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0000_0000;
            be_q        <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            wd_q        <= 5'd0;
            wreg_q      <= 1'b0;
            wdata_q     <= 32'h0000_0000;
            pc_q        <= `InitialPc;
            op_q        <= '0;
            off_q       <= 2'b00;
            hwd_q       <= 5'd0;
            hwreg_q     <= 1'b0;
            hpc_q       <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            bus_wdata_q <= bus_wdata_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
            pc_q        <= pc_d;
            op_q        <= op_d;
            off_q       <= off_d;
            hwd_q       <= hwd_d;
            hwreg_q     <= hwreg_d;
            hpc_q       <= hpc_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_req_s) begin
                    state_d = misalign_s ? ST_DONE : ST_BUS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (dmem.ack || (cnt_q == CNT_LAST)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUS;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; ack in the last BUS cycle beats the timeout.
    always_comb begin
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        bus_wdata_d = bus_wdata_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        wdata_d     = wdata_q;
        pc_d        = pc_q;
        op_d        = op_q;
        off_d       = off_q;
        hwd_d       = hwd_q;
        hwreg_d     = hwreg_q;
        hpc_d       = hpc_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_req_s && misalign_s) begin
                    wreg_d = 1'b0;
                    err_d  = 1'b1;
                end else if (mem_req_s) begin
                    req_d       = 1'b1;
                    we_d        = is_store(aluop_i);
                    addr_d      = {mem_addr_i[31:2], 2'b00};
                    be_d        = byte_en(aluop_i, mem_addr_i[1:0]);
                    bus_wdata_d = store_data(aluop_i, reg2_i);
                    cnt_d       = '0;
                    wreg_d      = 1'b0;
                    op_d        = aluop_i;
                    off_d       = mem_addr_i[1:0];
                    hwd_d       = wd_i;
                    hwreg_d     = wreg_i;
                    hpc_d       = pc_i;
                end else begin
                    wd_d    = wd_i;
                    wreg_d  = wreg_i & valid_i;
                    wdata_d = wdata_i;
                    pc_d    = pc_i;
                end
            end
            ST_BUS: begin
                if (dmem.ack) begin
                    req_d = 1'b0;
                    wd_d  = hwd_q;
                    pc_d  = hpc_q;
                    if (is_store(op_q)) begin
                        wreg_d = 1'b0;
                    end else begin
                        wreg_d  = hwreg_q;
                        wdata_d = align_load(op_q, off_q, dmem.rdata);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d  = 1'b0;
                    err_d  = 1'b1;
                    wreg_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                req_d = 1'b0;
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    // Stall while an access is being started or is outstanding; forced low during reset.
    always_comb begin
        if (!rst) begin
            stall_s = 1'b0;
        end else if (state_q == ST_BUS) begin
            stall_s = 1'b1;
        end else if (state_q == ST_IDLE) begin
            stall_s = mem_req_s;
        end else begin
            stall_s = 1'b0;
        end
    end

    assign stallreq_o = stall_s;
    assign wd_o       = wd_q;
    assign wreg_o     = wreg_q;
    assign wdata_o    = wdata_q;
    assign pc_o       = pc_q;
    assign bus_err_o  = err_q;
    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.be    = be_q;
    assign dmem.wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// ----------------------------------------------------------------------------
// tb_mem_access
//   Directed and randomized checks of mem_access against a behavioural model
//   of the load/store rules; the bench acts as the data memory.
// ----------------------------------------------------------------------------
`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef ALU_OP_LB
`define ALU_OP_LB 8'b1110_0000
`define ALU_OP_LH 8'b1110_0001
`define ALU_OP_LW 8'b1110_0011
`define ALU_OP_SB 8'b1110_1000
`define ALU_OP_SH 8'b1110_1001
`define ALU_OP_SW 8'b1110_1011
`define ALU_OP_ORI 8'b0010_0101
`endif
`ifndef InitialPc
`define InitialPc 32'hBFC0_0000
`endif

module tb_mem_access;
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             valid_i = 1'b0;
    logic [`AluOpBus] aluop_i = '0;
    logic [31:0]      mem_addr_i = 32'h0;
    logic [31:0]      reg2_i = 32'h0;
    logic [4:0]       wd_i = 5'd0;
    logic             wreg_i = 1'b0;
    logic [31:0]      wdata_i = 32'h0;
    logic [31:0]      pc_i = 32'h0;
    logic [4:0]       wd_o;
    logic             wreg_o;
    logic [31:0]      wdata_o;
    logic [31:0]      pc_o;
    logic             stallreq_o;
    logic             bus_err_o;
    int               vectors = 0;
    int               miscompares = 0;

    mem_access_if dmem_if ();

    mem_access #(.ACK_TIMEOUT(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .aluop_i    (aluop_i),
        .mem_addr_i (mem_addr_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .pc_i       (pc_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .pc_o       (pc_o),
        .stallreq_o (stallreq_o),
        .dmem       (dmem_if.master),
        .bus_err_o  (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: lane arithmetic straight from the load/store rules.
    function automatic bit m_is_store(input logic [`AluOpBus] op);
        return (op == `ALU_OP_SB) || (op == `ALU_OP_SH) || (op == `ALU_OP_SW);
    endfunction

    function automatic logic [3:0] m_be(input logic [`AluOpBus] op, input logic [31:0] a);
        int unsigned off;
        off = a[1:0];
        if (op == `ALU_OP_LB || op == `ALU_OP_SB) return 4'(1 << off);
        if (op == `ALU_OP_LH || op == `ALU_OP_SH) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [`AluOpBus] op, input logic [31:0] r);
        if (op == `ALU_OP_SB) return r[7:0] * 32'h0101_0101;
        if (op == `ALU_OP_SH) return r[15:0] * 32'h0001_0001;
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [`AluOpBus] op, input logic [31:0] a,
                                           input logic [31:0] d);
        logic [31:0] sh;
        int signed   v;
        if (op == `ALU_OP_LB) begin
            sh = d >> (8 * a[1:0]);
            v  = (sh[7:0] >= 8'h80) ? int'(sh[7:0]) - 256 : int'(sh[7:0]);
            return 32'(v);
        end
        if (op == `ALU_OP_LH) begin
            sh = d >> (a[1] ? 16 : 0);
            v  = (sh[15:0] >= 16'h8000) ? int'(sh[15:0]) - 65536 : int'(sh[15:0]);
            return 32'(v);
        end
        return d;
    endfunction

    task automatic do_alu(input logic [`AluOpBus] op, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata, input logic [31:0] pc, input logic valid);
        valid_i = valid; aluop_i = op; wd_i = wd; wreg_i = wreg; wdata_i = wdata; pc_i = pc;
        mem_addr_i = $urandom; reg2_i = $urandom;
        #1;
        chk("alu_stall", stallreq_o, 1'b0);
        tick();
        chk("alu_wd", wd_o, wd);
        chk("alu_wreg", wreg_o, wreg & valid);
        chk("alu_wdata", wdata_o, wdata);
        chk("alu_pc", pc_o, pc);
        chk("alu_noreq", dmem_if.req, 1'b0);
    endtask

    // delay >= 0: ack in BUS cycle delay+1; delay < 0: never ack.
    task automatic do_mem(input logic [`AluOpBus] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [4:0] wd, input logic wreg, input logic [31:0] pc,
                          input int delay, input logic [31:0] rdata);
        logic [4:0]  prev_wd;
        valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
        wd_i = wd; wreg_i = wreg; pc_i = pc; wdata_i = $urandom;
        #1;
        chk("issue_stall", stallreq_o, 1'b1);
        chk("issue_noreq_yet", dmem_if.req, 1'b0);
        prev_wd = wd_o;
        tick();
        chk("bus_req", dmem_if.req, 1'b1);
        chk("bus_we", dmem_if.we, m_is_store(op));
        chk("bus_addr", dmem_if.addr, {addr[31:2], 2'b00});
        chk("bus_be", dmem_if.be, m_be(op, addr));
        if (m_is_store(op)) chk("bus_wdata", dmem_if.wdata, m_wdata(op, reg2));
        chk("bus_wreg0", wreg_o, 1'b0);
        if (delay >= 0) begin
            for (int i = 0; i < delay; i++) begin
                chk("wait_stall", stallreq_o, 1'b1);
                tick();
                chk("wait_req", dmem_if.req, 1'b1);
            end
            dmem_if.ack = 1'b1; dmem_if.rdata = rdata;
            #1;
            chk("ack_stall", stallreq_o, 1'b1);
            tick();
            dmem_if.ack = 1'b0; dmem_if.rdata = $urandom;
            chk("done_stall", stallreq_o, 1'b0);
            chk("done_req", dmem_if.req, 1'b0);
            chk("done_err", bus_err_o, 1'b0);
            if (m_is_store(op)) begin
                chk("st_wreg", wreg_o, 1'b0);
            end else begin
                chk("ld_wreg", wreg_o, wreg);
                chk("ld_wd", wd_o, wd);
                chk("ld_pc", pc_o, pc);
                chk("ld_wdata", wdata_o, m_load(op, addr, rdata));
            end
        end else begin
            for (int i = 1; i < 16; i++) tick();
            chk("to_req_held16", dmem_if.req, 1'b1);
            chk("to_stall_held", stallreq_o, 1'b1);
            tick();
            chk("to_req_drop", dmem_if.req, 1'b0);
            chk("to_err", bus_err_o, 1'b1);
            chk("to_wreg", wreg_o, 1'b0);
            chk("to_stall", stallreq_o, 1'b0);
        end
        // DONE ignores the still-presented instruction: no re-issue next cycle.
        tick();
        chk("idle_err", bus_err_o, 1'b0);
        chk("idle_noreq", dmem_if.req, 1'b0);
        valid_i = 1'b0;
    endtask

    initial begin
        logic [`AluOpBus] ops[6];
        logic [`AluOpBus] op;
        logic [31:0]      a;
        int               dly;
        ops[0] = `ALU_OP_LB; ops[1] = `ALU_OP_LH; ops[2] = `ALU_OP_LW;
        ops[3] = `ALU_OP_SB; ops[4] = `ALU_OP_SH; ops[5] = `ALU_OP_SW;
        dmem_if.ack = 1'b0; dmem_if.rdata = 32'h0;

        // Reset state.
        tick(); tick();
        chk("rst_pc", pc_o, `InitialPc);
        chk("rst_wreg", wreg_o, 1'b0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_req", dmem_if.req, 1'b0);
        chk("rst_err", bus_err_o, 1'b0);
        chk("rst_stall", stallreq_o, 1'b0);
        rst = 1'b1;
        tick();

        // Directed cases.
        do_alu(`ALU_OP_ORI, 5'd5, 1'b1, 32'h0000_1234, 32'h0000_0040, 1'b1);
        do_alu(`ALU_OP_ORI, 5'd7, 1'b1, 32'hDEAD_BEEF, 32'h0000_0044, 1'b0);
        do_mem(`ALU_OP_LB, 32'h0000_0103, 32'h0, 5'd3, 1'b1, 32'h0000_0048, 2, 32'h80FF_FF00);
        do_mem(`ALU_OP_SH, 32'h0000_0202, 32'hABCD_1234, 5'd0, 1'b0, 32'h0000_004C, 0, 32'h0);
        do_mem(`ALU_OP_LW, 32'h0000_0300, 32'h0, 5'd9, 1'b1, 32'h0000_0050, -1, 32'h0);
        do_mem(`ALU_OP_LH, 32'h0000_0402, 32'h0, 5'd4, 1'b1, 32'h0000_0054, 1, 32'h8001_7FFE);
        do_mem(`ALU_OP_LW, 32'h0000_0500, 32'h0, 5'd6, 1'b1, 32'h0000_0058, 15, 32'hCAFE_F00D);
        do_mem(`ALU_OP_SB, 32'h0000_0601, 32'h1234_56A5, 5'd0, 1'b0, 32'h0000_005C, 0, 32'h0);

        // Reset in the middle of a bus access.
        valid_i = 1'b1; aluop_i = `ALU_OP_LW; mem_addr_i = 32'h0000_0700; pc_i = 32'h60;
        tick(); tick();
        chk("pre_rst_req", dmem_if.req, 1'b1);
        rst = 1'b0;
        #1;
        chk("midrst_req", dmem_if.req, 1'b0);
        chk("midrst_stall", stallreq_o, 1'b0);
        chk("midrst_pc", pc_o, `InitialPc);
        valid_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        do_mem(`ALU_OP_LW, 32'h0000_0704, 32'h0, 5'd8, 1'b1, 32'h0000_0064, 1, 32'h1357_9BDF);

        // Misaligned word access.
`ifdef MEM_ALIGN_CHECK_EN
        valid_i = 1'b1; aluop_i = `ALU_OP_LW; mem_addr_i = 32'h0000_0101; wreg_i = 1'b1;
        #1;
        chk("mis_stall", stallreq_o, 1'b1);
        tick();
        chk("mis_noreq", dmem_if.req, 1'b0);
        chk("mis_err", bus_err_o, 1'b1);
        chk("mis_wreg", wreg_o, 1'b0);
        chk("mis_done_stall", stallreq_o, 1'b0);
        tick();
        chk("mis_err_clr", bus_err_o, 1'b0);
        valid_i = 1'b0;
`else
        do_mem(`ALU_OP_LW, 32'h0000_0101, 32'h0, 5'd2, 1'b1, 32'h0000_0068, 0, 32'h2468_ACE0);
`endif

        // Randomized mix.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_alu(`ALU_OP_ORI, 5'($urandom), 1'($urandom), $urandom, $urandom,
                       1'($urandom));
            end else begin
                op = ops[$urandom_range(0, 5)];
                a  = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
                if (op == `ALU_OP_LH || op == `ALU_OP_SH) a[0] = 1'b0;
                if (op == `ALU_OP_LW || op == `ALU_OP_SW) a[1:0] = 2'b00;
`endif
                dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
                do_mem(op, a, $urandom, 5'($urandom), 1'($urandom), $urandom, dly, $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
